// File: rtl/stopwatch_pkg.sv
// Shared 7-segment font codes (active-low {dp,g,f,e,d,c,b,a}) and stopwatch field limits.
package stopwatch_pkg;

    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_DASH  = 8'hBF;
    localparam logic [7:0] FONT_BLANK = 8'hFF;
    localparam logic [7:0] DP_MASK    = 8'h7F;

    localparam logic [6:0] MSEC_MAX = 7'd99;
    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] HOUR_MAX = 7'd23;

endpackage

// File: rtl/fnd_digit_decoder.sv
// Decimal digit (or dash) to active-low 7-segment pattern {g..a}.
// Latency: combinational; no backpressure. Codes above 9 render blank.
module fnd_digit_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] font
);

    always_comb begin
        font = FONT_BLANK[6:0];
        if (dash) begin
            font = FONT_DASH[6:0];
        end else begin
            case (digit)
                4'd0:    font = FONT_0[6:0];
                4'd1:    font = FONT_1[6:0];
                4'd2:    font = FONT_2[6:0];
                4'd3:    font = FONT_3[6:0];
                4'd4:    font = FONT_4[6:0];
                4'd5:    font = FONT_5[6:0];
                4'd6:    font = FONT_6[6:0];
                4'd7:    font = FONT_7[6:0];
                4'd8:    font = FONT_8[6:0];
                4'd9:    font = FONT_9[6:0];
                default: font = FONT_BLANK[6:0];
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_fnd_ctrl.sv
// 4-digit common-anode FND scanner for the stopwatch (sec.msec or hour.min view).
// Latency: outputs registered on each scan tick; no backpressure, inputs sampled once per frame.
module stopwatch_fnd_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       i_sel,
    output logic [3:0] o_fnd_comm,
    output logic [7:0] o_fnd_font
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       ptr;
    logic [1:0]       next_ptr;
    logic             tick;
    logic             wrap;

    logic [6:0] snap_msec;
    logic [5:0] snap_sec;
    logic [5:0] snap_min;
    logic [4:0] snap_hour;
    logic       snap_sel;

    logic [6:0] cur_msec;
    logic [5:0] cur_sec;
    logic [5:0] cur_min;
    logic [4:0] cur_hour;
    logic       cur_sel;

    logic [6:0] field_val;
    logic [6:0] field_max;
    logic [6:0] tens;
    logic [6:0] ones;
    logic [6:0] digit_val;
    logic       dash;
    logic       dp_on;
    logic [6:0] seg;

    assign tick     = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    assign next_ptr = ptr + 2'd1;
    assign wrap     = tick && (ptr == 2'd3);

    // Digit 0 of a new frame is rendered from the values being latched this very edge.
    assign cur_msec = wrap ? i_msec : snap_msec;
    assign cur_sec  = wrap ? i_sec  : snap_sec;
    assign cur_min  = wrap ? i_min  : snap_min;
    assign cur_hour = wrap ? i_hour : snap_hour;
    assign cur_sel  = wrap ? i_sel  : snap_sel;

    always_comb begin
        field_val = cur_msec;
        field_max = MSEC_MAX;
        case ({cur_sel, next_ptr[1]})
            2'b00: begin
                field_val = cur_msec;
                field_max = MSEC_MAX;
            end
            2'b01: begin
                field_val = {1'b0, cur_sec};
                field_max = SEC_MAX;
            end
            2'b10: begin
                field_val = {1'b0, cur_min};
                field_max = MIN_MAX;
            end
            default: begin
                field_val = {2'b00, cur_hour};
                field_max = HOUR_MAX;
            end
        endcase
    end

    assign tens      = field_val / 7'd10;
    assign ones      = field_val % 7'd10;
    assign digit_val = next_ptr[0] ? tens : ones;
    assign dash      = (field_val > field_max) || (digit_val > 7'd9);
    assign dp_on     = (next_ptr == 2'd2) && (cur_msec < 7'd50);

    fnd_digit_decoder u_dec (
        .digit (digit_val[3:0]),
        .dash  (dash),
        .font  (seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt   <= '0;
            ptr        <= 2'd3;
            snap_msec  <= '0;
            snap_sec   <= '0;
            snap_min   <= '0;
            snap_hour  <= '0;
            snap_sel   <= 1'b0;
            o_fnd_comm <= 4'hF;
            o_fnd_font <= FONT_BLANK;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + CNT_W'(1);
            if (tick) begin
                ptr        <= next_ptr;
                o_fnd_comm <= ~(4'b0001 << next_ptr);
                o_fnd_font <= {1'b1, seg} & (dp_on ? DP_MASK : FONT_BLANK);
            end
            if (wrap) begin
                snap_msec <= i_msec;
                snap_sec  <= i_sec;
                snap_min  <= i_min;
                snap_hour <= i_hour;
                snap_sel  <= i_sel;
            end
        end
    end

endmodule
